// File: rtl/rx_elastic_ctrl.sv
// rx_elastic_ctrl
//   Pointer and rate-match controller for the 72-bit PCS RX dual-port FIFO.
//   It drives the memory addresses and write enable, and tracks occupancy and
//   empty/full. It also keeps the fill between two watermarks by working on
//   XGMII idle columns:
//     - When the FIFO is high, an incoming idle column is deleted (not written).
//     - When the FIFO is low, an idle column at the head is presented twice
//       (replayed). Only one replay is allowed per head word.
//   Everything runs in the single wclk domain. The memory has a combinational
//   read, so head_data is the word at raddr.
//
// Ports
//   wclk       clock; all logic is rising-edge
//   wrst_n     synchronous active-low reset
//   wr_en      push request; the memory takes wdata in the same cycle
//   wr_data    copy of the write word, used only to detect idle columns
//   rd_en      pop request from the consumer
//   head_data  memory rdata (word at raddr), used only to detect idle columns
//   waddr      memory write address
//   raddr      memory read address
//   wclken     memory write enable
//   wfull      FIFO full; also the memory write inhibit
//   rempty     FIFO empty; head_data is invalid while high
//   level      occupancy, 0 .. 2^ADDRSIZE
//   rd_ins     this rd_en was served as an idle replay (read pointer held)
//   drop_cnt   saturating count of deleted idle columns
//   ins_cnt    saturating count of replayed idle columns
//   ovf        sticky: push attempted while full
//   udf        sticky: pop attempted while empty
module rx_elastic_ctrl #(
  parameter int DATASIZE = 72,
  parameter int ADDRSIZE = 7,
  parameter int HI_WM    = 96,
  parameter int LO_WM    = 32,
  parameter int CNTW     = 16
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                wr_en,
  input  logic [DATASIZE-1:0] wr_data,
  input  logic                rd_en,
  input  logic [DATASIZE-1:0] head_data,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                wclken,
  output logic                wfull,
  output logic                rempty,
  output logic [ADDRSIZE:0]   level,
  output logic                rd_ins,
  output logic [CNTW-1:0]     drop_cnt,
  output logic [CNTW-1:0]     ins_cnt,
  output logic                ovf,
  output logic                udf
);

  localparam logic [ADDRSIZE:0]   HI_LVL   = (ADDRSIZE+1)'(HI_WM);
  localparam logic [ADDRSIZE:0]   LO_LVL   = (ADDRSIZE+1)'(LO_WM);
  // All eight lanes are control, and every lane carries the /I/ code 0x07.
  localparam logic [DATASIZE-1:0] IDLE_COL = DATASIZE'({8'hFF, {8{8'h07}}});

  function automatic logic is_idle(input logic [DATASIZE-1:0] w);
    return (w == IDLE_COL);
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (&c) ? c : c + CNTW'(1);
  endfunction

  // The pointers carry one extra wrap bit. This lets full and empty be told
  // apart when the low address bits are equal.
  logic [ADDRSIZE:0] wptr;
  logic [ADDRSIZE:0] rptr;
  logic              rep_done;

  logic              do_del;
  logic              do_rep;
  logic              do_pop;

  assign waddr  = wptr[ADDRSIZE-1:0];
  assign raddr  = rptr[ADDRSIZE-1:0];
  assign level  = wptr - rptr;
  assign rempty = (wptr == rptr);
  assign wfull  = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
                  (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);

  // The push and pop decisions both use the same pre-edge pointers. This means
  // a pop in the same cycle cannot make room for a push that arrives when the
  // FIFO is full. It also means a push cannot feed a pop that arrives when the
  // FIFO is empty.
  assign do_del = wr_en && !wfull && (level >= HI_LVL) && is_idle(wr_data);
  assign do_rep = rd_en && !rempty && (level <= LO_LVL) && is_idle(head_data) &&
                  !rep_done;
  assign do_pop = rd_en && !rempty && !do_rep;

  // Both strobes are gated by reset, so the memory and the consumer see
  // nothing while reset is held, even mid-stream.
  assign wclken = wrst_n && wr_en && !wfull && !do_del;
  assign rd_ins = wrst_n && do_rep;

  // ---- write side: pointer, idle deletion, overflow ----
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wptr     <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (wclken) begin
        wptr <= wptr + 1'b1;
      end
      if (do_del) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
      if (wr_en && wfull) begin
        ovf <= 1'b1;
      end
    end
  end

  // ---- read side: pointer, idle replay, underflow ----
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      rptr     <= '0;
      rep_done <= 1'b0;
      ins_cnt  <= '0;
      udf      <= 1'b0;
    end else begin
      if (do_rep) begin
        // Hold the head word for one more read. rep_done makes sure the next
        // read of this same word advances the pointer.
        rep_done <= 1'b1;
        ins_cnt  <= sat_inc(ins_cnt);
      end else if (do_pop) begin
        rptr     <= rptr + 1'b1;
        rep_done <= 1'b0;
      end
      if (rd_en && rempty) begin
        udf <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rx_elastic_ctrl.md
Name: rx_elastic_ctrl

Overview:
- Single-clock pointer and rate-match controller for the 72-bit PCS RX dual-port FIFO memory (DATASIZE/ADDRSIZE data store with combinational read).
- Generates waddr, raddr, wclken and wfull for the memory, and tracks fill level, empty and full.
- Performs XGMII idle-column deletion on the write side and idle-column replay (insertion) on the read side, holding fill between the watermarks.
- Sits between RX descrambler/decoder output and the XGMII-side consumer.

Parameters:
DATASIZE, 72, word width; [71:64] = per-lane ctrl bits, [63:0] = 8 data bytes (lane 0 = [7:0]).
ADDRSIZE, 7, memory address bits; depth = 2^ADDRSIZE = 128.
HI_WM, 96, level at or above which incoming idle columns are deleted.
LO_WM, 32, level at or below which head idle columns are replayed once.
CNTW, 16, width of drop/insert event counters.

Ports:
wclk  in  1  clock, all logic rising-edge.
wrst_n  in  1  synchronous active-low reset.
wr_en  in  1  push request; wr_data presented to memory wdata the same cycle.
wr_data  in  DATASIZE  copy of write word, used for idle detection only.
rd_en  in  1  pop request from consumer.
head_data  in  DATASIZE  memory rdata (word at raddr), used for idle detection.
waddr  out  ADDRSIZE  memory write address = wptr[ADDRSIZE-1:0].
raddr  out  ADDRSIZE  memory read address = rptr[ADDRSIZE-1:0].
wclken  out  1  memory write enable.
wfull  out  1  FIFO full; also drives memory write inhibit.
rempty  out  1  FIFO empty; head_data invalid when 1.
level  out  ADDRSIZE+1  occupancy, 0..2^ADDRSIZE.
rd_ins  out  1  pulse: current rd_en was served as an idle replay (pointer held).
drop_cnt  out  CNTW  saturating count of deleted idle columns.
ins_cnt  out  CNTW  saturating count of replayed idle columns.
ovf  out  1  sticky: push attempted while full.
udf  out  1  sticky: pop attempted while empty.

Behaviour:
- Pointers wptr/rptr are ADDRSIZE+1 bits (MSB is the wrap bit), binary, registered.
- level = wptr - rptr, modulo 2^(ADDRSIZE+1), combinational from the registered pointers.
- Status flags are combinational from the registered pointers:
  - rempty = (wptr == rptr).
  - wfull = (MSBs differ and low bits equal).
- Idle column: ctrl == 8'hFF and every data byte == 8'h07.
- Write decision, evaluated each cycle with wr_en=1:
  - wfull=1: no write, wclken=0, ovf<=1.
  - Else if level >= HI_WM and wr_data is idle: delete. wclken=0, wptr held, drop_cnt+1 (saturate at all-ones).
  - Else: wclken=1 and wptr+1 at the clock edge.
- wclken is combinational: wr_en & ~wfull & ~delete.
- Read decision, evaluated each cycle with rd_en=1:
  - rempty=1: no change, udf<=1.
  - Else if level <= LO_WM, head_data is idle, and rep_done=0: replay. rptr held, rd_ins=1 (combinational), rep_done<=1, ins_cnt+1 (saturating).
  - Else: rptr+1 and rep_done<=0.
- Replay limit: at most one replay per head word; the second rd_en on the same idle always advances.
- Simultaneous push and pop: both evaluated on the same pre-edge pointers and level.
  - Push at full is refused even if a pop occurs in the same cycle.
  - Pop at empty is refused even if a push occurs in the same cycle.
- Read latency: head_data is valid the cycle rempty falls. A word written at edge N is readable from cycle N+1.
- Wrap-around: the pointer low bits roll 2^ADDRSIZE-1 -> 0 and the MSB toggles. Full/empty remain correct across any number of wraps.
- Reset (wrst_n=0 sampled at an edge), including mid-stream:
  - Pointers, rep_done, drop_cnt, ins_cnt, ovf and udf all go to 0.
  - Outputs after reset: rempty=1, wfull=0, level=0, wclken=0, rd_ins=0.
  - While in reset, wclken is forced 0 and rd_ins is forced 0.
- Watermark requirement: 0 <= LO_WM < HI_WM <= 2^ADDRSIZE. Violation is a configuration error and is flagged by the bench assertion.

Test Plan:
- Reset then 128 non-idle pushes, no pops -> level=128, wfull=1, waddr back to 0. The 129th push gives wclken=0, ovf=1, level stays 128.
- 300 pushes and pops with rd_en one cycle behind, non-idle data -> read order equals write order across two wraps, level never exceeds 2, rempty=0 after the first write.
- Fill to 96 with data, then push an idle column -> wclken=0, drop_cnt=1, level=96. Then push a data word -> written, level=97.
- Level 20 with an idle column at the head, rd_en held for 2 cycles -> cycle 1: rd_ins=1, raddr unchanged, ins_cnt=1. Cycle 2: raddr+1, rd_ins=0.
- Empty FIFO with rd_en=1 and wr_en=1 in the same cycle -> pop refused, udf=1, level=1 next cycle, rempty=0.
- Mid-stream at level 50 with drop_cnt=3, assert wrst_n=0 for one cycle -> next cycle level=0, rempty=1, counters 0, waddr=raddr=0.
